// File: rtl/output_port_serializer_if.sv
// rtl/output_port_serializer_if.sv - grant and egress stream bundle for the port serializer
// master drives grants and egress ready; slave is the serializer side.
interface output_port_serializer_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8
) ();
  localparam int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic                            grant_valid;
  logic [SEL_WIDTH-1:0]            grant_sel;
  logic                            grant_ready;
  logic [OUT_WIDTH-1:0]            out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic                            err_sel;

  modport master (
    output in_data, grant_valid, grant_sel, out_ready,
    input  grant_ready, out_data, out_valid, out_last, err_sel
  );

  modport slave (
    input  in_data, grant_valid, grant_sel, out_ready,
    output grant_ready, out_data, out_valid, out_last, err_sel
  );
endinterface

// File: rtl/output_port_serializer.sv
// rtl/output_port_serializer.sv - egress stage: captures the granted channel word and streams it as beats
// A new grant is taken in IDLE or on the last-beat handshake, so back-to-back words have no bubble.
module output_port_serializer #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  output_port_serializer_if.slave    bus
);
  localparam int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEATS     = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("NUM_PORTS must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic [OUT_WIDTH-1:0]  out_data_q;
  logic                  out_last_q;
  logic                  err_sel_q;

  logic [DATA_WIDTH-1:0] sel_word;
  logic                  in_range;
  logic                  grant_ready;
  logic                  take;
  logic                  capture;
  logic                  drop;
  logic                  xfer;
  logic [CNT_WIDTH-1:0]  nxt_cnt;

  // Beat k of a word, in transmit order.
  function automatic logic [OUT_WIDTH-1:0] beat_of(input logic [DATA_WIDTH-1:0] w,
                                                   input logic [CNT_WIDTH-1:0]  k);
    int idx;
    idx = MSB_FIRST ? (BEATS - 1 - int'(k)) : int'(k);
    return w[idx*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  // Mux by comparison so an out-of-range select never indexes past in_data.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.grant_sel == SEL_WIDTH'(i)) begin
        sel_word = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_range    = 32'(bus.grant_sel) < NUM_PORTS;
  assign grant_ready = (state == IDLE) || (out_last_q && bus.out_ready);
  assign take        = bus.grant_valid && grant_ready;
  assign capture     = take && in_range;
  assign drop        = take && !in_range;
  assign xfer        = (state == SEND) && bus.out_ready;
  assign nxt_cnt     = beat_cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      word       <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      err_sel_q  <= 1'b0;
    end else begin
      err_sel_q <= drop;
      if (capture) begin
        state      <= SEND;
        word       <= sel_word;
        beat_cnt   <= '0;
        out_data_q <= beat_of(sel_word, '0);
        out_last_q <= (BEATS == 1);
      end else if (xfer) begin
        if (out_last_q) begin
          state      <= IDLE;
          out_last_q <= 1'b0;
        end else begin
          beat_cnt   <= nxt_cnt;
          out_data_q <= beat_of(word, nxt_cnt);
          out_last_q <= (32'(nxt_cnt) == BEATS - 1);
        end
      end
    end
  end

  assign bus.grant_ready = grant_ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = (state == SEND);
  assign bus.out_last    = out_last_q;
  assign bus.err_sel     = err_sel_q;
endmodule

// File: tb/tb_output_port_serializer.sv
// tb/tb_output_port_serializer.sv - directed bench for output_port_serializer
// Four instances: default, 3-port, LSB-first and single-beat.
module tb_output_port_serializer;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  output_port_serializer_if #(.NUM_PORTS(4), .DATA_WIDTH(16), .OUT_WIDTH(8))  a ();
  output_port_serializer_if #(.NUM_PORTS(3), .DATA_WIDTH(16), .OUT_WIDTH(8))  b ();
  output_port_serializer_if #(.NUM_PORTS(4), .DATA_WIDTH(16), .OUT_WIDTH(8))  c ();
  output_port_serializer_if #(.NUM_PORTS(4), .DATA_WIDTH(16), .OUT_WIDTH(16)) d ();

  output_port_serializer #(.NUM_PORTS(4), .DATA_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(a));
  output_port_serializer #(.NUM_PORTS(3), .DATA_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(b));
  output_port_serializer #(.NUM_PORTS(4), .DATA_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(c));
  output_port_serializer #(.NUM_PORTS(4), .DATA_WIDTH(16), .OUT_WIDTH(16), .MSB_FIRST(1'b1))
    dut_d (.clk(clk), .rst(rst), .bus(d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] dat, input logic l);
    chk({tag, "_valid"}, 32'(a.out_valid), 32'(v));
    if (v) chk({tag, "_data"}, 32'(a.out_data), 32'(dat));
    chk({tag, "_last"}, 32'(a.out_last), 32'(l));
  endtask

  initial begin
    rst = 1'b1;
    a.in_data = '0; a.grant_valid = 1'b0; a.grant_sel = '0; a.out_ready = 1'b0;
    b.in_data = '0; b.grant_valid = 1'b0; b.grant_sel = '0; b.out_ready = 1'b0;
    c.in_data = '0; c.grant_valid = 1'b0; c.grant_sel = '0; c.out_ready = 1'b0;
    d.in_data = '0; d.grant_valid = 1'b0; d.grant_sel = '0; d.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(a.out_valid), 32'h0);
    chk("rst_data",  32'(a.out_data),  32'h0);
    chk("rst_last",  32'(a.out_last),  32'h0);
    chk("rst_err",   32'(b.err_sel),   32'h0);
    chk("rst_gready", 32'(a.grant_ready), 32'h1);

    // basic two-beat word, MSB first
    a.in_data = {16'h0000, 16'hA55A, 16'h0000, 16'h0000};
    a.grant_sel = 2'd2; a.grant_valid = 1'b1; a.out_ready = 1'b1;
    step();
    a.grant_valid = 1'b0;
    chk_a("t1_b0", 1'b1, 8'hA5, 1'b0);
    #1 chk("t1_gready_b0", 32'(a.grant_ready), 32'h0);
    step();
    chk_a("t1_b1", 1'b1, 8'h5A, 1'b1);
    chk("t1_gready_b1", 32'(a.grant_ready), 32'h1);
    step();
    chk_a("t1_idle", 1'b0, 8'h00, 1'b0);

    // backpressure on first beat
    a.out_ready = 1'b0; a.grant_valid = 1'b1;
    step();
    a.grant_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_a("t2_hold", 1'b1, 8'hA5, 1'b0);
      step();
    end
    chk_a("t2_hold4", 1'b1, 8'hA5, 1'b0);
    a.out_ready = 1'b1;
    step();
    chk_a("t2_b1", 1'b1, 8'h5A, 1'b1);
    step();
    chk_a("t2_idle", 1'b0, 8'h00, 1'b0);

    // back-to-back grants, no bubble
    a.in_data = {16'h3344, 16'h0000, 16'h0000, 16'h1122};
    a.grant_sel = 2'd0; a.grant_valid = 1'b1;
    step();
    chk_a("t3_11", 1'b1, 8'h11, 1'b0);
    a.grant_sel = 2'd3;
    step();
    chk_a("t3_22", 1'b1, 8'h22, 1'b1);
    chk("t3_gready", 32'(a.grant_ready), 32'h1);
    step();
    a.grant_valid = 1'b0;
    chk_a("t3_33", 1'b1, 8'h33, 1'b0);
    step();
    chk_a("t3_44", 1'b1, 8'h44, 1'b1);
    step();
    chk_a("t3_idle", 1'b0, 8'h00, 1'b0);

    // reset mid-word
    a.in_data = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    a.grant_sel = 2'd1; a.grant_valid = 1'b1;
    step();
    a.grant_valid = 1'b0;
    chk_a("t5_be", 1'b1, 8'hBE, 1'b0);
    step();
    chk_a("t5_ef_pending", 1'b1, 8'hEF, 1'b1);
    rst = 1'b1; a.out_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_valid", 32'(a.out_valid), 32'h0);
    chk("t5_data",  32'(a.out_data),  32'h0);
    chk("t5_last",  32'(a.out_last),  32'h0);
    a.out_ready = 1'b1;
    step();
    chk("t5_after", 32'(a.out_valid), 32'h0);

    // out-of-range select on a 3-port instance
    b.in_data = {16'h0000, 16'hC3D4, 16'h0000};
    b.out_ready = 1'b1; b.grant_sel = 2'd3; b.grant_valid = 1'b1;
    step();
    b.grant_valid = 1'b0;
    chk("t4_err",   32'(b.err_sel),   32'h1);
    chk("t4_valid", 32'(b.out_valid), 32'h0);
    step();
    chk("t4_err_clr", 32'(b.err_sel),   32'h0);
    chk("t4_valid2",  32'(b.out_valid), 32'h0);
    b.grant_sel = 2'd1; b.grant_valid = 1'b1;
    step();
    b.grant_valid = 1'b0;
    chk("t4_c3", 32'(b.out_data), 32'hC3);
    chk("t4_c3v", 32'(b.out_valid), 32'h1);
    step();
    chk("t4_d4", 32'(b.out_data), 32'hD4);
    chk("t4_d4l", 32'(b.out_last), 32'h1);
    b.grant_sel = 2'd3; b.grant_valid = 1'b1;
    step();
    b.grant_valid = 1'b0;
    chk("t4_lasterr", 32'(b.err_sel),   32'h1);
    chk("t4_lastidle", 32'(b.out_valid), 32'h0);

    // LSB first; input change after capture is ignored
    c.in_data = {16'h0000, 16'h0000, 16'hA55A, 16'h0000};
    c.out_ready = 1'b1; c.grant_sel = 2'd1; c.grant_valid = 1'b1;
    step();
    c.grant_valid = 1'b0;
    c.in_data = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    chk("t6_b0", 32'(c.out_data), 32'h5A);
    chk("t6_l0", 32'(c.out_last), 32'h0);
    step();
    chk("t6_b1", 32'(c.out_data), 32'hA5);
    chk("t6_l1", 32'(c.out_last), 32'h1);
    step();
    chk("t6_idle", 32'(c.out_valid), 32'h0);

    // single-beat words, one per cycle
    d.in_data = {16'h0000, 16'h5678, 16'h0000, 16'h1234};
    d.out_ready = 1'b1; d.grant_sel = 2'd0; d.grant_valid = 1'b1;
    step();
    chk("t7_w0", 32'(d.out_data), 32'h1234);
    chk("t7_l0", 32'(d.out_last), 32'h1);
    chk("t7_gr", 32'(d.grant_ready), 32'h1);
    d.grant_sel = 2'd2;
    step();
    d.grant_valid = 1'b0;
    chk("t7_w1", 32'(d.out_data), 32'h5678);
    chk("t7_v1", 32'(d.out_valid), 32'h1);
    step();
    chk("t7_idle", 32'(d.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
